// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix operand/result responder.
// Optional build macro used by the top: MATRIX_RESP_ORDER_CHECK_EN.
package matrix_pkg;

    typedef enum logic [1:0] {
        JOB_IDLE = 2'd0,
        JOB_RUN  = 2'd1,
        JOB_DONE = 2'd2
    } job_state_t;

    typedef enum logic {
        ACK_IDLE = 1'b0,
        ACK_HOLD = 1'b1
    } ack_state_t;

    localparam logic [1:0] SEL_A    = 2'd0;
    localparam logic [1:0] SEL_B    = 2'd1;
    localparam logic [1:0] SEL_SEED = 2'd2;

    localparam logic [31:0] FP_ONE = 32'h3F800000;

endpackage

// File: rtl/matrix_ack_responder.sv
// Receiving side of the z_stb/z_ack result handshake: one capture and one
// single-cycle acknowledge per strobe, then waits for the strobe to drop.
module matrix_ack_responder
    import matrix_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       z_stb_i,
    output logic       cap_en_o,
    output logic       z_ack_o,
    output ack_state_t state_o
);

    // Handshake: z_stb_i seen high in ACK_IDLE is accepted (cap_en_o) that
    // cycle; z_ack_o is high for exactly the following cycle; a new strobe is
    // only accepted after z_stb_i has been observed low in ACK_HOLD.
    ack_state_t state_q, state_d;
    logic       z_ack_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACK_IDLE;
            z_ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            z_ack_q <= cap_en_o;
        end
    end

    always_comb begin
        state_d  = state_q;
        cap_en_o = 1'b0;
        case (state_q)
            ACK_IDLE: begin
                if (z_stb_i) begin
                    cap_en_o = 1'b1;
                    state_d  = ACK_HOLD;
                end
            end
            ACK_HOLD: begin
                if (!z_stb_i) state_d = ACK_IDLE;
            end
            default: state_d = ACK_IDLE;
        endcase
    end

    assign z_ack_o = z_ack_q;
    assign state_o = state_q;

endmodule

// File: rtl/matrix_operand_responder.sv
// Memory-side partner of the sequential matrix multiplier: holds A, B, C and
// the seed word. Optional result-order checker under MATRIX_RESP_ORDER_CHECK_EN.
module matrix_operand_responder
    import matrix_pkg::*;
#(
    parameter int M     = 4,
    parameter int M_LEN = $clog2(M)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [1:0]           wr_sel,
    input  logic [M_LEN-1:0]     wr_i,
    input  logic [M_LEN-1:0]     wr_j,
    input  logic [31:0]          wr_data,
    input  logic                 go,
    input  logic [M_LEN-1:0]     rd_i,
    input  logic [M_LEN-1:0]     rd_j,
    output logic [31:0]          rd_data,
    output logic                 busy,
    output logic                 job_done,
    output logic                 wr_err,
    output logic                 mul_start,
    input  logic                 mul_done,
    input  logic [M_LEN-1:0]     a_i,
    input  logic [M_LEN-1:0]     a_j,
    input  logic [M_LEN-1:0]     b_i,
    input  logic [M_LEN-1:0]     b_j,
    output logic [31:0]          a_in,
    output logic [31:0]          b_in,
    output logic [31:0]          current_element,
    input  logic [31:0]          z_out,
    input  logic [M_LEN-1:0]     z_i,
    input  logic [M_LEN-1:0]     z_j,
    input  logic                 z_stb,
    output logic                 z_ack,
    output logic [3*M_LEN:0]     z_count,
`ifdef MATRIX_RESP_ORDER_CHECK_EN
    output logic                 order_err,
`endif
    output job_state_t           job_state_dbg,
    output ack_state_t           ack_state_dbg
);

    // One bit wider than three indices so the saturation value M^3 fits.
    localparam int CNT_W = 3 * M_LEN + 1;
    localparam logic [CNT_W-1:0] M3_C = CNT_W'(M * M * M);

    function automatic logic in_rng(input logic [M_LEN-1:0] i,
                                    input logic [M_LEN-1:0] j);
        return (int'(i) < M) && (int'(j) < M);
    endfunction

    logic [31:0] a_q [M][M];
    logic [31:0] b_q [M][M];
    logic [31:0] c_q [M][M];
    logic [31:0] seed_q;
    logic [31:0] a_in_q, b_in_q, rd_data_q;

    job_state_t       state_q, state_d;
    logic             start;
    logic             mul_start_q, wr_err_q;
    logic             host_wr_ok;
    logic             cap_en;
    logic [CNT_W-1:0] z_count_q, z_count_d;

    matrix_ack_responder u_ack (
        .clk      (clk),
        .rst      (rst),
        .z_stb_i  (z_stb),
        .cap_en_o (cap_en),
        .z_ack_o  (z_ack),
        .state_o  (ack_state_dbg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= JOB_IDLE;
            mul_start_q <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_start_q <= start;
            wr_err_q    <= wr_en && (state_q == JOB_RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            JOB_IDLE, JOB_DONE: begin
                if (go) begin
                    state_d = JOB_RUN;
                    start   = 1'b1;
                end
            end
            JOB_RUN: begin
                if (mul_done) state_d = JOB_DONE;
            end
            default: state_d = JOB_IDLE;
        endcase
    end

    assign host_wr_ok = wr_en && (state_q != JOB_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < M; i++)
                for (int j = 0; j < M; j++) begin
                    a_q[i][j] <= '0;
                    b_q[i][j] <= '0;
                end
            seed_q <= '0;
        end else if (host_wr_ok) begin
            case (wr_sel)
                SEL_A:    if (in_rng(wr_i, wr_j)) a_q[wr_i][wr_j] <= wr_data;
                SEL_B:    if (in_rng(wr_i, wr_j)) b_q[wr_i][wr_j] <= wr_data;
                SEL_SEED: seed_q <= wr_data;
                default: ;
            endcase
        end
    end

    // A capture in the same cycle as a job start lands after the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < M; i++)
                for (int j = 0; j < M; j++)
                    c_q[i][j] <= '0;
        end else begin
            if (start)
                for (int i = 0; i < M; i++)
                    for (int j = 0; j < M; j++)
                        c_q[i][j] <= '0;
            if (cap_en && in_rng(z_i, z_j)) c_q[z_i][z_j] <= z_out;
        end
    end

    always_comb begin
        z_count_d = z_count_q;
        if (start) z_count_d = '0;
        if (cap_en && (z_count_d != M3_C)) z_count_d = z_count_d + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_count_q <= '0;
            a_in_q    <= '0;
            b_in_q    <= '0;
            rd_data_q <= '0;
        end else begin
            z_count_q <= z_count_d;
            a_in_q    <= in_rng(a_i, a_j)   ? a_q[a_i][a_j]   : '0;
            b_in_q    <= in_rng(b_i, b_j)   ? b_q[b_i][b_j]   : '0;
            rd_data_q <= in_rng(rd_i, rd_j) ? c_q[rd_i][rd_j] : '0;
        end
    end

`ifdef MATRIX_RESP_ORDER_CHECK_EN
    // Expected result sequence: row-major (i,j), each pair repeated M times.
    logic [M_LEN-1:0] exp_i_q, exp_j_q, exp_k_q;
    logic             order_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_i_q     <= '0;
            exp_j_q     <= '0;
            exp_k_q     <= '0;
            order_err_q <= 1'b0;
        end else if (start) begin
            exp_i_q     <= '0;
            exp_j_q     <= '0;
            exp_k_q     <= '0;
            order_err_q <= 1'b0;
        end else begin
            if (cap_en) begin
                if ((z_i != exp_i_q) || (z_j != exp_j_q)) order_err_q <= 1'b1;
                if (exp_k_q == M_LEN'(M - 1)) begin
                    exp_k_q <= '0;
                    if (exp_j_q == M_LEN'(M - 1)) begin
                        exp_j_q <= '0;
                        exp_i_q <= (exp_i_q == M_LEN'(M - 1)) ? '0 : exp_i_q + M_LEN'(1);
                    end else begin
                        exp_j_q <= exp_j_q + M_LEN'(1);
                    end
                end else begin
                    exp_k_q <= exp_k_q + M_LEN'(1);
                end
            end
            if ((state_q == JOB_RUN) && (z_count_q == M3_C) && !mul_done)
                order_err_q <= 1'b1;
        end
    end

    assign order_err = order_err_q;
`endif

    assign rd_data         = rd_data_q;
    assign a_in            = a_in_q;
    assign b_in            = b_in_q;
    assign current_element = seed_q;
    assign busy            = (state_q == JOB_RUN);
    assign job_done        = (state_q == JOB_DONE);
    assign wr_err          = wr_err_q;
    assign mul_start       = mul_start_q;
    assign z_count         = z_count_q;
    assign job_state_dbg   = state_q;

endmodule
